tpu_job_sequencer: RTL and testbench
====================================

TPU_JOB_SEQUENCER -- requirements
Module: tpu_job_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32; width of all byte addresses.
REQ-002 SHALL have parameter MAX_MATRIX_SIZE, default 16; largest supported N for an NxN matrix.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- ACLK  in  1  clock; all state updates on its rising edge.
- ARESETn  in  1  asynchronous active-low reset.
REQ-004 SHALL have the following job-descriptor ports:
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  sequencer can accept a job.
- cfg_a_addr, cfg_b_addr, cfg_c_addr  in  ADDR_WIDTH each  base byte addresses of A, B, C.
- cfg_size  in  8  N.
REQ-005 SHALL have the following DMA request and completion ports:
- dma_req_valid  out  1  burst request valid.
- dma_req_ready  in  1  DMA accepts request.
- dma_req_write  out  1  1 = store C, 0 = load A/B.
- dma_req_sel  out  2  00 = A, 01 = B, 10 = C.
- dma_req_addr  out  ADDR_WIDTH  burst start byte address.
- dma_req_len  out  8  AXI LEN (beats-1).
- dma_done  in  1  one-cycle pulse when the accepted burst completes.
- dma_err  in  1  qualifies dma_done; 1 = burst got SLVERR/DECERR.
REQ-006 SHALL have the following TPU control ports:
- tpu_start  out  1  one-cycle start pulse.
- tpu_done  in  1  compute finished (pulse or level).
- tpu_size  out  8  latched N.
REQ-007 SHALL have the following status ports:
- busy  out  1  job in progress.
- irq  out  1  sticky completion interrupt.
- irq_clr  in  1  clears irq.
- status_err  out  1  last job failed.

Function
REQ-008 SHALL implement the states IDLE, LOAD_A, LOAD_B, COMPUTE, STORE_C, FINISH; each LOAD/STORE state SHALL have REQ and WAIT sub-phases.
REQ-009 In IDLE, cfg_ready SHALL be 1; in all other states it SHALL be 0. A job SHALL be accepted on cfg_valid&&cfg_ready, which latches all cfg_* inputs and clears status_err.
REQ-010 If the accepted cfg_size is 0 or greater than MAX_MATRIX_SIZE, the sequencer SHALL go directly to FINISH with status_err=1 and issue no DMA request.
REQ-011 Otherwise it SHALL enter LOAD_A/REQ, and dma_req_valid SHALL assert on the cycle after acceptance.
REQ-012 Each matrix SHALL be moved as N row bursts:
- row r address = base + r*N*4, computed modulo 2^ADDR_WIDTH (wrap permitted).
- dma_req_len = N-1.
- row counter runs 0..N-1.
REQ-013 dma_req_valid and all dma_req_* fields SHALL be held stable until dma_req_ready; the handshake cycle SHALL move the phase REQ->WAIT and deassert dma_req_valid.
REQ-014 In WAIT, dma_done with dma_err=0 SHALL do one of the following:
- if row < N-1: increment the row counter and return to REQ.
- if row = N-1: clear the counter and advance LOAD_A->LOAD_B->COMPUTE, or STORE_C->FINISH.
REQ-015 dma_done with dma_err=1 in any WAIT SHALL abort to FINISH with status_err=1; remaining rows and stages SHALL be skipped.
REQ-016 dma_done outside WAIT SHALL be ignored.
REQ-017 In COMPUTE:
- tpu_start SHALL pulse high exactly one cycle, on the first cycle of COMPUTE.
- tpu_done SHALL be honoured only after that pulse; it moves the state to STORE_C.
- tpu_done during any other state SHALL be ignored.
REQ-018 STORE_C SHALL issue C row bursts per REQ-012 with dma_req_write=1 and dma_req_sel=10.
REQ-019 FINISH SHALL last one cycle: set irq=1 and return to IDLE.
REQ-020 irq SHALL stay 1 until irq_clr; if irq_clr and the irq set occur in the same cycle, set SHALL win.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 tpu_size SHALL reflect the latched N.
REQ-023 dma_req_write SHALL be 0 for A and B loads.

Reset
REQ-024 On ARESETn low, the block SHALL immediately enter IDLE, including mid-job; outstanding DMA and TPU activity is abandoned.
REQ-025 During and after reset the outputs SHALL be: cfg_ready=1, dma_req_valid=0, dma_req_write=0, dma_req_sel=00, dma_req_addr=0, dma_req_len=0, tpu_start=0, tpu_size=0, busy=0, irq=0, status_err=0.

Verification
REQ-026 Nominal job: N=4, A=0x1000, B=0x2000, C=0x3000, dma_req_ready=1, DMA completes each burst in 2 cycles.
- Required: A read requests at 0x1000/0x1010/0x1020/0x1030 with len=3; then B requests; then one tpu_start pulse.
- Required after tpu_done: 4 write requests at 0x3000..0x3030; irq=1; status_err=0.
REQ-027 Bad size: cfg_size=0, then cfg_size=17 -> no dma_req_valid; irq=1 and status_err=1 each time.
REQ-028 DMA error: dma_err=1 on the second B row -> no further requests and no tpu_start; FINISH with status_err=1.
REQ-029 Backpressure: dma_req_ready held low 5 cycles -> dma_req_valid and its fields stay stable throughout; exactly one request is counted.
REQ-030 Ignored inputs and reset mid-job: spurious tpu_done during LOAD_A is ignored; ARESETn low during STORE_C -> all outputs at reset values and cfg_ready=1.
REQ-031 irq collision: irq_clr asserted in the FINISH cycle -> irq=1 on the next cycle.

Source files
------------

// File: rtl/tpu_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_job_sequencer
//  Description : Runs one matrix-multiply job. It loads A and B row by row
//                through a DMA request/done interface, starts the TPU, stores
//                C row by row, then raises a sticky completion interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module tpu_job_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_MATRIX_SIZE = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // job descriptor
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_a_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_b_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_c_addr,
    input  logic [7:0]            cfg_size,
    // DMA request / completion
    output logic                  dma_req_valid,
    input  logic                  dma_req_ready,
    output logic                  dma_req_write,
    output logic [1:0]            dma_req_sel,
    output logic [ADDR_WIDTH-1:0] dma_req_addr,
    output logic [7:0]            dma_req_len,
    input  logic                  dma_done,
    input  logic                  dma_err,
    // TPU control
    output logic                  tpu_start,
    input  logic                  tpu_done,
    output logic [7:0]            tpu_size,
    // status
    output logic                  busy,
    output logic                  irq,
    input  logic                  irq_clr,
    output logic                  status_err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_A_REQ   = 4'd1,
        S_A_WAIT  = 4'd2,
        S_B_REQ   = 4'd3,
        S_B_WAIT  = 4'd4,
        S_COMPUTE = 4'd5,
        S_C_REQ   = 4'd6,
        S_C_WAIT  = 4'd7,
        S_FINISH  = 4'd8
    } state_t;

    state_t                state;
    logic [7:0]            row;
    logic [ADDR_WIDTH-1:0] b_base;
    logic [ADDR_WIDTH-1:0] c_base;

    logic                  size_bad;
    logic                  last_row;
    logic [ADDR_WIDTH-1:0] row_stride;

    // A zero-sized or oversized job is rejected without touching the DMA
    assign size_bad   = (cfg_size == 8'd0) || ({24'd0, cfg_size} > 32'(MAX_MATRIX_SIZE));
    assign last_row   = (row == (tpu_size - 8'd1));
    // One row of 32-bit words is N*4 bytes; the address add wraps naturally
    assign row_stride = ADDR_WIDTH'({tpu_size, 2'b00});

    // Job state machine; every output is a register updated here
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= S_IDLE;
            row           <= 8'd0;
            b_base        <= '0;
            c_base        <= '0;
            cfg_ready     <= 1'b1;
            dma_req_valid <= 1'b0;
            dma_req_write <= 1'b0;
            dma_req_sel   <= 2'b00;
            dma_req_addr  <= '0;
            dma_req_len   <= 8'd0;
            tpu_start     <= 1'b0;
            tpu_size      <= 8'd0;
            busy          <= 1'b0;
            irq           <= 1'b0;
            status_err    <= 1'b0;
        end else begin
            tpu_start <= 1'b0;

            // Setting the interrupt takes priority over a same-cycle clear
            if (state == S_FINISH) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        tpu_size   <= cfg_size;
                        b_base     <= cfg_b_addr;
                        c_base     <= cfg_c_addr;
                        row        <= 8'd0;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        status_err <= size_bad;
                        if (size_bad) begin
                            state <= S_FINISH;
                        end else begin
                            state         <= S_A_REQ;
                            dma_req_valid <= 1'b1;
                            dma_req_write <= 1'b0;
                            dma_req_sel   <= 2'b00;
                            dma_req_addr  <= cfg_a_addr;
                            dma_req_len   <= cfg_size - 8'd1;
                        end
                    end
                end

                // Request phases: hold the burst until the DMA takes it
                S_A_REQ, S_B_REQ, S_C_REQ: begin
                    if (dma_req_ready) begin
                        dma_req_valid <= 1'b0;
                        state <= (state == S_A_REQ) ? S_A_WAIT :
                                 (state == S_B_REQ) ? S_B_WAIT : S_C_WAIT;
                    end
                end

                // Wait phases: next row, next stage, or abort on a bus error
                S_A_WAIT, S_B_WAIT, S_C_WAIT: begin
                    if (dma_done) begin
                        if (dma_err) begin
                            state      <= S_FINISH;
                            status_err <= 1'b1;
                            row        <= 8'd0;
                        end else if (!last_row) begin
                            row           <= row + 8'd1;
                            dma_req_addr  <= dma_req_addr + row_stride;
                            dma_req_valid <= 1'b1;
                            state <= (state == S_A_WAIT) ? S_A_REQ :
                                     (state == S_B_WAIT) ? S_B_REQ : S_C_REQ;
                        end else begin
                            row <= 8'd0;
                            if (state == S_A_WAIT) begin
                                state         <= S_B_REQ;
                                dma_req_valid <= 1'b1;
                                dma_req_sel   <= 2'b01;
                                dma_req_addr  <= b_base;
                            end else if (state == S_B_WAIT) begin
                                state     <= S_COMPUTE;
                                tpu_start <= 1'b1;
                            end else begin
                                state <= S_FINISH;
                            end
                        end
                    end
                end

                // tpu_done counts only once the start pulse has been issued
                S_COMPUTE: begin
                    if (tpu_done && !tpu_start) begin
                        state         <= S_C_REQ;
                        dma_req_valid <= 1'b1;
                        dma_req_write <= 1'b1;
                        dma_req_sel   <= 2'b10;
                        dma_req_addr  <= c_base;
                    end
                end

                S_FINISH: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpu_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tpu_job_sequencer
//  Description : Directed self-checking bench for tpu_job_sequencer with a
//                scoreboard of expected DMA bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tpu_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_a_addr = '0;
    logic [31:0] cfg_b_addr = '0;
    logic [31:0] cfg_c_addr = '0;
    logic [7:0]  cfg_size = '0;
    logic        dma_req_valid;
    logic        dma_req_ready = 1'b1;
    logic        dma_req_write;
    logic [1:0]  dma_req_sel;
    logic [31:0] dma_req_addr;
    logic [7:0]  dma_req_len;
    logic        dma_done = 1'b0;
    logic        dma_err = 1'b0;
    logic        tpu_start;
    logic        tpu_done = 1'b0;
    logic [7:0]  tpu_size;
    logic        busy;
    logic        irq;
    logic        irq_clr = 1'b0;
    logic        status_err;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   req_cnt = 0;
    int   start_cnt = 0;
    int   c0;
    int   s0;

    tpu_job_sequencer #(.ADDR_WIDTH(32), .MAX_MATRIX_SIZE(16)) dut (
        .ACLK         (clk),
        .ARESETn      (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_a_addr   (cfg_a_addr),
        .cfg_b_addr   (cfg_b_addr),
        .cfg_c_addr   (cfg_c_addr),
        .cfg_size     (cfg_size),
        .dma_req_valid(dma_req_valid),
        .dma_req_ready(dma_req_ready),
        .dma_req_write(dma_req_write),
        .dma_req_sel  (dma_req_sel),
        .dma_req_addr (dma_req_addr),
        .dma_req_len  (dma_req_len),
        .dma_done     (dma_done),
        .dma_err      (dma_err),
        .tpu_start    (tpu_start),
        .tpu_done     (tpu_done),
        .tpu_size     (tpu_size),
        .busy         (busy),
        .irq          (irq),
        .irq_clr      (irq_clr),
        .status_err   (status_err)
    );

    always #5 clk = ~clk;

    // Count accepted bursts and start pulses mid-cycle
    always @(negedge clk) begin
        if (dma_req_valid && dma_req_ready) req_cnt++;
        if (tpu_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_cfg_ready"}, cfg_ready, 1);
        chk({pfx, "_req_valid"}, dma_req_valid, 0);
        chk({pfx, "_req_write"}, dma_req_write, 0);
        chk({pfx, "_req_sel"}, dma_req_sel, 0);
        chk({pfx, "_req_addr"}, dma_req_addr, 0);
        chk({pfx, "_req_len"}, dma_req_len, 0);
        chk({pfx, "_tpu_start"}, tpu_start, 0);
        chk({pfx, "_tpu_size"}, tpu_size, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_irq"}, irq, 0);
        chk({pfx, "_status_err"}, status_err, 0);
    endtask

    task automatic push_rows(input logic wr, input logic [1:0] sel,
                             input logic [31:0] base, input int n, input int rows);
        for (int r = 0; r < rows; r++) begin
            req_t e;
            e.wr   = wr;
            e.sel  = sel;
            e.addr = base + 32'(r * n * 4);
            e.len  = 8'(n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Wait for a request, score it, then complete it two cycles after acceptance
    task automatic serve_req(input logic err);
        int   waited = 0;
        req_t e;
        while (!dma_req_valid && waited < 50) begin
            tick();
            waited++;
        end
        chk("req_seen", dma_req_valid, 1);
        if (dma_req_valid) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("req_write", dma_req_write, e.wr);
            chk("req_sel", dma_req_sel, e.sel);
            chk("req_addr", dma_req_addr, e.addr);
            chk("req_len", dma_req_len, e.len);
            tick();
            chk("req_drop", dma_req_valid, 0);
            tick();
            dma_done = 1'b1;
            dma_err  = err;
            tick();
            dma_done = 1'b0;
            dma_err  = 1'b0;
        end
    endtask

    task automatic start_job(input logic [7:0] n, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
        chk("idle_cfg_ready", cfg_ready, 1);
        cfg_valid  = 1'b1;
        cfg_size   = n;
        cfg_a_addr = a;
        cfg_b_addr = b;
        cfg_c_addr = c;
        tick();
        cfg_valid  = 1'b0;
        cfg_a_addr = '0;
        cfg_b_addr = '0;
        cfg_c_addr = '0;
        chk("accept_busy", busy, 1);
        chk("accept_cfg_ready", cfg_ready, 0);
        chk("accept_tpu_size", tpu_size, n);
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Nominal N=4 job
        push_rows(1'b0, 2'b00, 32'h1000, 4, 4);
        push_rows(1'b0, 2'b01, 32'h2000, 4, 4);
        c0 = req_cnt;
        s0 = start_cnt;
        start_job(8'd4, 32'h1000, 32'h2000, 32'h3000);
        chk("valid_after_accept", dma_req_valid, 1);
        repeat (8) serve_req(1'b0);
        chk("tpu_start_pulse", tpu_start, 1);
        chk("compute_no_req", dma_req_valid, 0);
        tick();
        chk("tpu_start_once", tpu_start, 0);
        repeat (3) tick();
        chk("compute_hold", dma_req_valid, 0);
        push_rows(1'b1, 2'b10, 32'h3000, 4, 4);
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        repeat (4) serve_req(1'b0);
        chk("finish_busy", busy, 1);
        tick();
        chk("nom_irq", irq, 1);
        chk("nom_status_err", status_err, 0);
        chk("nom_busy_idle", busy, 0);
        chk("nom_cfg_ready", cfg_ready, 1);
        chk("nom_req_count", req_cnt - c0, 12);
        chk("nom_start_count", start_cnt - s0, 1);
        chk("nom_sb_empty", exp_q.size(), 0);
        repeat (2) tick();
        chk("irq_sticky", irq, 1);
        clear_irq();

        // Bad size 0
        c0 = req_cnt;
        start_job(8'd0, 32'h1000, 32'h2000, 32'h3000);
        chk("size0_err", status_err, 1);
        chk("size0_no_valid", dma_req_valid, 0);
        tick();
        chk("size0_irq", irq, 1);
        chk("size0_busy", busy, 0);
        clear_irq();

        // Bad size 17, with irq_clr colliding with the set
        start_job(8'd17, 32'h1000, 32'h2000, 32'h3000);
        irq_clr = 1'b1;
        tick();
        chk("irq_collision", irq, 1);
        chk("size17_err", status_err, 1);
        tick();
        irq_clr = 1'b0;
        chk("irq_clr_after", irq, 0);
        chk("badsize_no_req", req_cnt - c0, 0);

        // N=1 job with backpressure and spurious tpu_done/dma_done
        dma_req_ready = 1'b0;
        push_rows(1'b0, 2'b00, 32'h4000, 1, 1);
        push_rows(1'b0, 2'b01, 32'h5000, 1, 1);
        start_job(8'd1, 32'h4000, 32'h5000, 32'h6000);
        chk("err_cleared", status_err, 0);
        c0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", dma_req_valid, 1);
            chk("bp_addr", dma_req_addr, 32'h4000);
            chk("bp_len", dma_req_len, 0);
            chk("bp_sel", dma_req_sel, 0);
            tpu_done = (i == 1);
            dma_done = (i == 3);
            tick();
        end
        tpu_done = 1'b0;
        dma_done = 1'b0;
        chk("bp_no_handshake", req_cnt - c0, 0);
        dma_req_ready = 1'b1;
        serve_req(1'b0);
        chk("bp_one_req", req_cnt - c0, 1);
        serve_req(1'b0);
        chk("n1_tpu_start", tpu_start, 1);
        push_rows(1'b1, 2'b10, 32'h6000, 1, 1);
        tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        serve_req(1'b0);
        tick();
        chk("n1_irq", irq, 1);
        chk("n1_status_err", status_err, 0);
        chk("n1_sb_empty", exp_q.size(), 0);
        clear_irq();

        // DMA error on the second B row
        push_rows(1'b0, 2'b00, 32'h8000, 4, 4);
        push_rows(1'b0, 2'b01, 32'h9000, 4, 2);
        c0 = req_cnt;
        s0 = start_cnt;
        start_job(8'd4, 32'h8000, 32'h9000, 32'hA000);
        repeat (5) serve_req(1'b0);
        serve_req(1'b1);
        chk("derr_status", status_err, 1);
        chk("derr_no_valid", dma_req_valid, 0);
        chk("derr_no_start", tpu_start, 0);
        tick();
        chk("derr_irq", irq, 1);
        chk("derr_busy", busy, 0);
        repeat (3) tick();
        chk("derr_req_count", req_cnt - c0, 6);
        chk("derr_start_count", start_cnt - s0, 0);
        chk("derr_sb_empty", exp_q.size(), 0);
        clear_irq();

        // N=2 with address wrap, then reset during STORE_C
        push_rows(1'b0, 2'b00, 32'hFFFF_FFFC, 2, 2);
        push_rows(1'b0, 2'b01, 32'h0000_0100, 2, 2);
        start_job(8'd2, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_0200);
        repeat (4) serve_req(1'b0);
        chk("wrap_tpu_start", tpu_start, 1);
        dma_req_ready = 1'b0;
        tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        chk("store_valid", dma_req_valid, 1);
        chk("store_write", dma_req_write, 1);
        chk("store_sel", dma_req_sel, 2'b10);
        chk("store_addr", dma_req_addr, 32'h0000_0200);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        dma_req_ready = 1'b1;
        tick();
        chk("post_rst_cfg_ready", cfg_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
